ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: stall  in  6  stall bus from the hazard controller; bit k set means stage k is held.
REQ-004 SHALL have ports: id_to_ex_bus  in  159  {pc[31:0], inst[31:0], alu_op[11:0], sel_src1[2:0], sel_src2[3:0], ram_en, ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1[31:0], rdata2[31:0]}, MSB first.
REQ-005 SHALL have ports: ex_to_mem_bus  out  141  {pc[31:0], ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], result[31:0], hilo_we, hi[31:0], lo[31:0]}.
REQ-006 SHALL have ports: ex_to_rf_bus  out  38  {rf_we, rf_waddr[4:0], result[31:0]}, the forwarding path into decode.
REQ-007 SHALL have ports: data_sram_en  out  1;  data_sram_wen  out  4;  data_sram_addr  out  32;  data_sram_wdata  out  32.
REQ-008 SHALL have ports: stallreq_for_ex  out  1  request to hold the pipeline while the divider is busy.

Function
REQ-009 SHALL register id_to_ex_bus into an internal register on each clk edge as follows: stall[2]=1 and stall[3]=0 loads all-zero (bubble); stall[2]=0 loads the input; otherwise the register holds.
REQ-010 SHALL select src1 as rdata1 (sel_src1[0]), pc (sel_src1[1]), or {27'b0, inst[10:6]} (sel_src1[2]); with no select bit set, src1 SHALL be 0.
REQ-011 SHALL select src2 as rdata2 (sel_src2[0]), sign-extended inst[15:0] (sel_src2[1]), 32'd8 (sel_src2[2]), or zero-extended inst[15:0] (sel_src2[3]); with no select bit set, src2 SHALL be 0.
REQ-012 SHALL compute the ALU result from the one-hot alu_op {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
- add/sub: 32-bit wrap-around, no overflow trap.
- slt: signed compare; sltu: unsigned compare; result is 0 or 1.
- Shifts: shift src2 by src1[4:0].
- lui: {src2[15:0], 16'b0}.
- All-zero alu_op: result 0.
REQ-013 SHALL compute data_sram_addr = rdata1 + sign-extended inst[15:0].
REQ-014 SHALL drive data_sram_en = ram_en.
REQ-015 SHALL derive data_sram_wen from inst[31:26] and addr[1:0]:
- sb (0x28): one-hot byte lane.
- sh (0x29): 4'b0011 or 4'b1100.
- sw (0x2B): 4'b1111.
- Any other opcode: 0.
REQ-016 SHALL drive data_sram_wdata as rs... rt data (rdata2) replicated across lanes: sb {4{byte}}, sh {2{half}}, sw word.
REQ-017 SHALL recognise div (opcode 0, func 0x1A) and divu (opcode 0, func 0x1B) and service them with a radix-2 restoring divider using states IDLE, BUSY, DONE.
REQ-018 Divider state transitions SHALL be:
- IDLE→BUSY on a div or divu in the register; BUSY lasts exactly 32 cycles; BUSY→DONE; DONE→IDLE on the next edge where stall[3]=0.
- While DONE is waiting for stall[3]=0, the DONE state and its hi/lo values SHALL be retained.
REQ-019 For div, the divider SHALL operate on absolute values and then apply signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-020 stallreq_for_ex SHALL be 1 while the state is IDLE with a div/divu present, and while the state is BUSY; it SHALL be 0 in DONE and in all other cases.
REQ-021 In DONE the stage SHALL assert hilo_we=1 with lo=quotient and hi=remainder; in all other states hilo_we=0.
REQ-022 A divisor of 0 SHALL complete in the same 33-cycle sequence with quotient 32'hFFFFFFFF and remainder equal to the dividend.
REQ-023 A bubble loaded while the divider is BUSY SHALL NOT abort the division.
REQ-024 ex_to_rf_bus SHALL mirror rf_we, rf_waddr, and result combinationally.
REQ-025 When sel_rf_res=1 (load), ex_to_rf_bus rf_we SHALL be forced to 0.

Reset
REQ-026 On rst=1 the stage SHALL asynchronously clear the internal register and set the divider to IDLE with its counter, quotient and remainder at 0.
REQ-027 While rst=1 every output SHALL be 0.
REQ-028 A reset asserted during BUSY SHALL abandon the division with no hilo_we pulse.

Verification
REQ-029 The bench SHALL cover: addu with rdata1=5, rdata2=7 → result 12, ex_to_rf_bus={1, rd, 12} one cycle after load.
REQ-030 The bench SHALL cover: sb with rdata1=0x1000, offset=3, rdata2=0xAB → addr 0x1003, wen 4'b1000, wdata 0xABABABAB.
REQ-031 The bench SHALL cover: div of -7 by 2 → stallreq_for_ex high for 33 cycles, then hilo_we=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 The bench SHALL cover: divu of 9 by 0 → lo=0xFFFFFFFF, hi=9 after 33 cycles.
REQ-033 The bench SHALL cover: stall[2]=1 and stall[3]=0 → next cycle all bus outputs 0, and stall[2]=stall[3]=1 → register holds its value.
REQ-034 The bench SHALL cover: rst pulse at BUSY cycle 10 → stallreq_for_ex=0 and outputs 0 immediately, with no hilo_we afterward.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a five-stage MIPS-style pipeline.
// Holds the ALU, store byte-lane formatting and a 32-step restoring divider for div/divu.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [140:0] ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

  // Pipeline register: a bubble is inserted when decode is held but execute is not.
  logic [158:0] id_ex_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else if (stall[2] && !stall[3]) id_ex_q <= '0;
    else if (!stall[2]) id_ex_q <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;
  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr,
          sel_rf_res, rdata1, rdata2} = id_ex_q;

  logic [31:0] imm_sext, imm_zext, src1, src2, sra_res, alu_res;
  logic        slt_bit, sltu_bit;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};
  assign src1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8) | ({32{sel_src2[3]}} & imm_zext);
  assign slt_bit  = $signed(src1) < $signed(src2);
  assign sltu_bit = src1 < src2;
  assign sra_res  = $signed(src2) >>> src1[4:0];

  // One-hot AND-OR select; an all-zero op naturally yields zero.
  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'b0, slt_bit})
                 | ({32{alu_op[8]}}  & {31'b0, sltu_bit})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  logic [5:0] opcode;
  assign opcode         = inst[31:26];
  assign data_sram_en   = ram_en;
  assign data_sram_addr = rdata1 + imm_sext;

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = rdata2;
    case (opcode)
      6'h28: begin
        data_sram_wen   = 4'b0001 << data_sram_addr[1:0];
        data_sram_wdata = {4{rdata2[7:0]}};
      end
      6'h29: begin
        data_sram_wen   = data_sram_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rdata2[15:0]}};
      end
      6'h2B: data_sram_wen = 4'b1111;
      default: ;
    endcase
  end

  logic is_div, is_divu, div_req;
  assign is_div  = (opcode == 6'h00) && (inst[5:0] == 6'h1A);
  assign is_divu = (opcode == 6'h00) && (inst[5:0] == 6'h1B);
  assign div_req = is_div || is_divu;

  div_state_t state, state_n;
  logic [4:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n         = state;
    stallreq_for_ex = 1'b0;
    case (state)
      IDLE: if (div_req) begin
        stallreq_for_ex = 1'b1;
        state_n         = BUSY;
      end
      BUSY: begin
        stallreq_for_ex = 1'b1;
        if (cnt == 5'd31) state_n = DONE;
      end
      DONE:    if (!stall[3]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are captured at start, so later bubbles in id_ex_q cannot disturb the division.
  logic [31:0] quo, rem, dvsr;
  logic        neg_q, neg_r, dz;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  assign rem_sh = {rem, quo[31]};
  assign trial  = {1'b0, rem_sh} - {2'b0, dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; quo <= '0; rem <= '0; dvsr <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
    end else if (state == IDLE && div_req) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= (is_div && rdata1[31]) ? -rdata1 : rdata1;
      dvsr  <= (is_div && rdata2[31]) ? -rdata2 : rdata2;
      neg_q <= is_div && (rdata1[31] ^ rdata2[31]);
      neg_r <= is_div && rdata1[31];
      dz    <= (rdata2 == 32'b0);
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      if (!trial[33]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  logic        hilo_we;
  logic [31:0] hi, lo;
  assign hilo_we = (state == DONE);
  assign lo = hilo_we ? (dz ? 32'hFFFF_FFFF : (neg_q ? -quo : quo)) : 32'b0;
  assign hi = hilo_we ? (neg_r ? -rem : rem) : 32'b0;

  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, alu_res,
                          hilo_we, hi, lo};
  // Loads return their value from memory, so they never forward from this stage.
  assign ex_to_rf_bus  = {rf_we & ~sel_rf_res, rf_waddr, alu_res};

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], trial[32]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage, checked every cycle against a behavioural
// model of the stage plus literal expectations for the key scenarios.
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall = '0;
  logic [158:0] id_to_ex_bus = '0;
  logic [140:0] ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         stallreq_for_ex;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [158:0] pack(input logic [31:0] pc, inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ram_en, input logic [3:0] ram_wen,
      input logic rf_we, input logic [4:0] waddr, input logic sel_rf_res,
      input logic [31:0] r1, r2);
    return {pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf_res, r1, r2};
  endfunction

  // ---------------- behavioural model ----------------
  // m_cnt: 0 = no division in flight, 1..32 = divider working, 33 = result available.
  logic [158:0] m_reg = '0;
  int           m_cnt = 0;
  logic [31:0]  m_hi = '0, m_lo = '0;
  logic         m_is_div, m_signed;
  logic [31:0]  m_r1, m_r2;
  assign m_r1     = m_reg[63:32];
  assign m_r2     = m_reg[31:0];
  assign m_signed = (m_reg[100:95] == 6'h1A);
  assign m_is_div = (m_reg[126:121] == 6'h00) && (m_reg[100:95] == 6'h1A || m_reg[100:95] == 6'h1B);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= '0; m_cnt <= 0; m_hi <= '0; m_lo <= '0;
    end else begin
      if (m_cnt == 0) begin
        if (m_is_div) begin
          m_cnt <= 1;
          if (m_r2 == 32'd0) begin
            m_lo <= 32'hFFFF_FFFF; m_hi <= m_r1;
          end else if (m_signed) begin
            m_lo <= $signed(m_r1) / $signed(m_r2); m_hi <= $signed(m_r1) % $signed(m_r2);
          end else begin
            m_lo <= m_r1 / m_r2; m_hi <= m_r1 % m_r2;
          end
        end
      end else if (m_cnt <= 32) m_cnt <= m_cnt + 1;
      else if (!stall[3]) m_cnt <= 0;
      if (stall[2] && !stall[3]) m_reg <= '0;
      else if (!stall[2]) m_reg <= id_to_ex_bus;
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin : compare
    logic [31:0] pc, inst, a, b, res, addr, wd;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2, wen;
    logic        done, sreq, store;
    {pc, inst, op, s1, s2} = m_reg[158:76];
    case (s1)
      3'b001:  a = m_r1;
      3'b010:  a = pc;
      3'b100:  a = {27'd0, inst[10:6]};
      default: a = 32'd0;
    endcase
    case (s2)
      4'b0001: b = m_r2;
      4'b0010: b = {{16{inst[15]}}, inst[15:0]};
      4'b0100: b = 32'd8;
      4'b1000: b = {16'd0, inst[15:0]};
      default: b = 32'd0;
    endcase
    case (op)
      12'h800: res = a + b;
      12'h400: res = a - b;
      12'h200: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h100: res = (a < b) ? 32'd1 : 32'd0;
      12'h080: res = a & b;
      12'h040: res = ~(a | b);
      12'h020: res = a | b;
      12'h010: res = a ^ b;
      12'h008: res = b << a[4:0];
      12'h004: res = b >> a[4:0];
      12'h002: res = $signed(b) >>> a[4:0];
      12'h001: res = {b[15:0], 16'h0};
      default: res = 32'd0;
    endcase
    addr  = m_r1 + {{16{inst[15]}}, inst[15:0]};
    wen   = 4'b0;
    wd    = m_r2;
    store = 1'b1;
    case (inst[31:26])
      6'h28:   begin wen = 4'b0001 << addr[1:0]; wd = {4{m_r2[7:0]}}; end
      6'h29:   begin wen = addr[1] ? 4'b1100 : 4'b0011; wd = {2{m_r2[15:0]}}; end
      6'h2B:   wen = 4'b1111;
      default: store = 1'b0;
    endcase
    done = (m_cnt == 33);
    sreq = (m_cnt == 0 && m_is_div) || (m_cnt >= 1 && m_cnt <= 32);
    check("mem_bus", ex_to_mem_bus, {m_reg[158:127], m_reg[75], m_reg[74:71], m_reg[64],
          m_reg[70], m_reg[69:65], res, done, done ? m_hi : 32'd0, done ? m_lo : 32'd0});
    check("rf_bus", ex_to_rf_bus, {m_reg[70] & ~m_reg[64], m_reg[69:65], res});
    check("sram_ctl", {data_sram_en, data_sram_wen, data_sram_addr}, {m_reg[75], wen, addr});
    if (store) check("sram_wdata", data_sram_wdata, wd);
    if (rst) check("rst_wdata", data_sram_wdata, 32'd0);
    check("stallreq", stallreq_for_ex, sreq);
  end

  // ---------------- driver tasks ----------------
  task automatic alu_vec(input string name, input logic [11:0] op, input logic [2:0] s1,
      input logic [3:0] s2, input logic [31:0] inst, r1, r2, exp);
    id_to_ex_bus = pack(32'hBFC0_0000, inst, op, s1, s2, 1'b0, 4'b0, 1'b1, 5'd3, 1'b0, r1, r2);
    stall = 6'b0;
    @(negedge clk);
    check(name, ex_to_rf_bus, {1'b1, 5'd3, exp});
  endtask

  task automatic store_vec(input string name, input logic [31:0] inst, r1, r2,
      input logic [3:0] e_wen, input logic [31:0] e_addr, e_wd);
    id_to_ex_bus = pack(32'hBFC0_0100, inst, 12'h800, 3'b001, 4'b0010, 1'b1, 4'b0, 1'b0,
                        5'd0, 1'b0, r1, r2);
    stall = 6'b0;
    @(negedge clk);
    check(name, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, e_wen, e_addr, e_wd});
  endtask

  task automatic run_div(input string name, input logic is_signed, input logic [31:0] r1, r2,
      input logic [31:0] e_lo, e_hi, input int bubble_at);
    int cycles = 0;
    logic [31:0] inst;
    inst = {6'd0, 5'd1, 5'd2, 10'd0, is_signed ? 6'h1A : 6'h1B};
    id_to_ex_bus = pack(32'hBFC0_0200, inst, 12'h000, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b0,
                        5'd0, 1'b0, r1, r2);
    stall = 6'b0;
    @(negedge clk);
    id_to_ex_bus = '0;
    while (stallreq_for_ex && cycles < 100) begin
      cycles++;
      stall = (cycles == bubble_at) ? 6'b000100 : 6'b001111;
      @(negedge clk);
    end
    stall = 6'b001111;
    check({name, "_stall_cycles"}, cycles, 33);
    check({name, "_done"}, {ex_to_mem_bus[64], ex_to_mem_bus[63:0]}, {1'b1, e_hi, e_lo});
    @(negedge clk);
    check({name, "_done_hold"}, {stallreq_for_ex, ex_to_mem_bus[64:0]}, {1'b0, 1'b1, e_hi, e_lo});
    stall = 6'b0;
    @(negedge clk);
    check({name, "_released"}, {stallreq_for_ex, ex_to_mem_bus[64]}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    check("reset_outputs", {ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
          data_sram_addr, data_sram_wdata, stallreq_for_ex}, '0);
    rst = 1'b0;

    alu_vec("addu",   12'h800, 3'b001, 4'b0001, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 32'd12);
    alu_vec("subu",   12'h400, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("add_wrap", 12'h800, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("slt",    12'h200, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu",   12'h100, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("slt_ext", 12'h200, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
    alu_vec("sltu_ext", 12'h100, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1);
    alu_vec("and",    12'h080, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("nor",    12'h040, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu_vec("or",     12'h020, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    alu_vec("xor",    12'h010, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_vec("sll",    12'h008, 3'b100, 4'b0001, {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00}, 32'h0000_DEAD, 32'h0000_000F, 32'h0000_00F0);
    alu_vec("srl",    12'h004, 3'b100, 4'b0001, {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h02}, 32'h0, 32'h8000_0000, 32'h0800_0000);
    alu_vec("sra",    12'h002, 3'b100, 4'b0001, {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 32'h0, 32'h8000_0000, 32'hF800_0000);
    alu_vec("lui",    12'h001, 3'b000, 4'b1000, {6'h0F, 5'd0, 5'd2, 16'h1234}, 32'h0, 32'h0, 32'h1234_0000);
    alu_vec("addiu_sext", 12'h800, 3'b001, 4'b0010, {6'h09, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd0, 32'd9);
    alu_vec("pc_plus8", 12'h800, 3'b010, 4'b0100, {6'h03, 26'd0}, 32'd0, 32'd0, 32'hBFC0_0008);
    alu_vec("no_op",  12'h000, 3'b001, 4'b0001, {6'h09, 5'd1, 5'd2, 16'd0}, 32'd5, 32'd7, 32'd0);

    store_vec("sb_lane3", {6'h28, 5'd1, 5'd2, 16'd3}, 32'h1000, 32'hAB, 4'b1000, 32'h1003, 32'hABAB_ABAB);
    store_vec("sb_lane1", {6'h28, 5'd1, 5'd2, 16'd1}, 32'h1000, 32'h1234_5678, 4'b0010, 32'h1001, 32'h7878_7878);
    store_vec("sh_high", {6'h29, 5'd1, 5'd2, 16'd6}, 32'h2000, 32'h1234_BEEF, 4'b1100, 32'h2006, 32'hBEEF_BEEF);
    store_vec("sh_low",  {6'h29, 5'd1, 5'd2, 16'd4}, 32'h2000, 32'h1234_BEEF, 4'b0011, 32'h2004, 32'hBEEF_BEEF);
    store_vec("sw_negoff", {6'h2B, 5'd1, 5'd2, 16'hFFFC}, 32'h3000, 32'hCAFE_F00D, 4'b1111, 32'h2FFC, 32'hCAFE_F00D);

    id_to_ex_bus = pack(32'hBFC0_0300, {6'h23, 5'd1, 5'd7, 16'd4}, 12'h800, 3'b001, 4'b0010,
                        1'b1, 4'b0, 1'b1, 5'd7, 1'b1, 32'h100, 32'h0);
    @(negedge clk);
    check("load_rf_we_gated", {ex_to_rf_bus[37], ex_to_mem_bus[102], data_sram_wen, data_sram_addr},
          {1'b0, 1'b1, 4'b0, 32'h104});

    // bubble, then hold
    alu_vec("pre_bubble", 12'h800, 3'b001, 4'b0001, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 32'd12);
    stall = 6'b000100;
    @(negedge clk);
    check("bubble_zero", {ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_addr}, '0);
    alu_vec("pre_hold", 12'h800, 3'b001, 4'b0001, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 32'd12);
    stall = 6'b001100;
    id_to_ex_bus = pack(32'h0, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd9, 1'b0, 32'd1, 32'd1);
    repeat (2) @(negedge clk);
    check("hold_keeps", ex_to_rf_bus, {1'b1, 5'd3, 32'd12});
    stall = 6'b0;
    id_to_ex_bus = '0;
    @(negedge clk);

    run_div("div_neg7_2",  1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    run_div("divu_9_0",    1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, -1);
    run_div("div_100_n7_bubble", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 5);
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF, -1);
    run_div("div_neg8_0",  1'b1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, -1);

    // reset during BUSY
    id_to_ex_bus = pack(32'hBFC0_0400, {6'd0, 5'd1, 5'd2, 10'd0, 6'h1B}, 12'h000, 3'b001, 4'b0001,
                        1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3);
    stall = 6'b0;
    @(negedge clk);
    stall = 6'b001111;
    id_to_ex_bus = '0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy_outputs", {ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
          data_sram_addr, data_sram_wdata, stallreq_for_ex}, '0);
    @(negedge clk);
    rst = 1'b0;
    stall = 6'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ex_to_mem_bus[64] !== 1'b0) seen = 1'b1;
    end
    check("rst_busy_no_hilo", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
